tt_schedule_table: RTL and testbench
====================================

TT_SCHEDULE_TABLE -- requirements
Module: tt_schedule_table

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of schedule entries (index width 3).
REQ-002 SHALL have parameter LEAD, default 16: cycles of global time before window_start at which an entry is issued.
REQ-003 SHALL have ports clk input 1 (system clock) and rst input 1 (asynchronous, active-high reset); the block uses one clock and an asynchronous active-high reset.
REQ-004 SHALL have port cfg_wr input 1: write one table entry.
REQ-005 SHALL have port cfg_addr input 3: entry index to write.
REQ-006 SHALL have ports cfg_port_number input 16, cfg_buffer_number input 16, cfg_window_start input 64, cfg_window_end input 64, cfg_flow_id input 16, cfg_tt_length input 16: entry fields.
REQ-007 SHALL have ports cfg_entry_count input 4 (active entries, 0..DEPTH) and cfg_enable input 1 (run schedule).
REQ-008 SHALL have ports in_table_rdy input 1 (downstream checker ready) and in_global_time input 64 (global time).
REQ-009 SHALL have ports in_tt_wr input 1, in_tt_ctrl input 8 (TT stream monitor; ctrl==1 marks last word) and in_tt_flag_clear input 1.
REQ-010 SHALL have port out_table_wr output 1: one-cycle entry strobe.
REQ-011 SHALL have ports out_port_number 16, out_buffer_number 16, out_window_start 64, out_window_end 64, out_flow_id 16, out_tt_length 16, all outputs holding the issued entry.
REQ-012 SHALL have ports out_tt_flag output 1 (TT frame pending), out_missed output 1 (one-cycle miss pulse), out_entry_index output 3, out_cycle_count output 16 and out_miss_count output 16.

Function
REQ-013 SHALL implement states IDLE, EVAL, ISSUE and HOLD.
REQ-014 In IDLE, SHALL move to EVAL when cfg_enable==1 and cfg_entry_count!=0; otherwise it SHALL stay in IDLE with index 0.
REQ-015 In EVAL, SHALL read the entry at the current index from a registered copy.
REQ-016 In EVAL, if in_global_time > window_end, SHALL pulse out_missed, increment out_miss_count (wrapping at 16 bits), advance the index and stay in EVAL.
REQ-017 In EVAL, if in_global_time + LEAD >= window_start (64-bit compare, no overflow wrap of the sum) and in_table_rdy==1, SHALL go to ISSUE; otherwise it SHALL stay in EVAL.
REQ-018 In ISSUE, SHALL drive out_table_wr=1 for exactly one cycle, register all out_* entry fields that cycle and keep them stable until the next ISSUE, advance the index, and go to HOLD.
REQ-019 In HOLD, SHALL ignore in_table_rdy for one cycle, then wait for in_table_rdy==1 before returning to EVAL, so that a ready level not yet dropped by the checker is never double-counted.
REQ-020 Index advance SHALL go from cfg_entry_count-1 to 0 and increment out_cycle_count (16-bit wrap).
REQ-021 If cfg_entry_count is lowered below the index+1, the next advance SHALL wrap to 0.
REQ-022 If cfg_enable drops, the block SHALL finish any ISSUE/HOLD, then return to IDLE with index=0; the counters SHALL hold their values.
REQ-023 On cfg_wr, SHALL write the entry the same cycle; an entry issued in the same cycle SHALL carry the pre-write data.
REQ-024 out_tt_flag SHALL be set on the first in_tt_wr word of a frame.
REQ-025 A frame SHALL end on in_tt_wr with in_tt_ctrl==1; a single-word frame both sets the flag and ends the frame.
REQ-026 out_tt_flag SHALL be cleared by in_tt_flag_clear; if clear and set occur in the same cycle, set SHALL win.
REQ-027 out_entry_index SHALL show the index of the entry currently being evaluated.

Reset
REQ-028 rst SHALL force IDLE, index 0, all outputs 0, all counters 0 and the frame tracker idle.
REQ-029 Table contents SHALL be cleared by rst.
REQ-030 rst asserted mid-ISSUE SHALL drop out_table_wr immediately.

Verification
REQ-031 Entry0 {port 2, buf 1, start 100, end 200}, count 1, enable, rdy=1, time 83 -> no strobe; time 84 -> one out_table_wr pulse, out_window_start=100, out_cycle_count=1.
REQ-032 Count 3, time beyond entry1 window_end -> out_missed pulse, out_miss_count=1, entry2 issued next; index wraps to 0.
REQ-033 rdy held 1 continuously across ISSUE -> exactly one strobe per rdy low/high cycle of the checker, never two consecutive.
REQ-034 Frame of 3 words, ctrl==1 on the last word, then in_tt_flag_clear -> flag 1 from the first word until the clear; clear coincident with a new frame's first word -> flag stays 1.
REQ-035 cfg_wr to entry 0 in its ISSUE cycle -> outputs show old data; the next cycle shows new data.
REQ-036 rst pulsed during HOLD -> all outputs 0 asynchronously, restart from entry 0 after enable.

Source files
------------

// File: rtl/tt_schedule_table.sv
// Time-triggered schedule table: walks the configured entries in order and issues each
// one to the downstream checker LEAD cycles ahead of its window, counting missed windows.
module tt_schedule_table #(
   parameter int DEPTH = 8,
   parameter int LEAD  = 16,
   localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_wr,
   input  logic [IW-1:0] cfg_addr,
   input  logic [15:0]   cfg_port_number,
   input  logic [15:0]   cfg_buffer_number,
   input  logic [63:0]   cfg_window_start,
   input  logic [63:0]   cfg_window_end,
   input  logic [15:0]   cfg_flow_id,
   input  logic [15:0]   cfg_tt_length,
   input  logic [CW-1:0] cfg_entry_count,
   input  logic          cfg_enable,
   input  logic          in_table_rdy,
   input  logic [63:0]   in_global_time,
   input  logic          in_tt_wr,
   input  logic [7:0]    in_tt_ctrl,
   input  logic          in_tt_flag_clear,
   output logic          out_table_wr,
   output logic [15:0]   out_port_number,
   output logic [15:0]   out_buffer_number,
   output logic [63:0]   out_window_start,
   output logic [63:0]   out_window_end,
   output logic [15:0]   out_flow_id,
   output logic [15:0]   out_tt_length,
   output logic          out_tt_flag,
   output logic          out_missed,
   output logic [IW-1:0] out_entry_index,
   output logic [15:0]   out_cycle_count,
   output logic [15:0]   out_miss_count
);

   typedef enum logic [1:0] {IDLE, EVAL, ISSUE, HOLD} state_t;

   state_t      state;
   logic        hold_seen;
   logic        in_frame;
   logic [15:0] tbl_port  [DEPTH];
   logic [15:0] tbl_buf   [DEPTH];
   logic [63:0] tbl_start [DEPTH];
   logic [63:0] tbl_end   [DEPTH];
   logic [15:0] tbl_flow  [DEPTH];
   logic [15:0] tbl_len   [DEPTH];

   logic [63:0]   cur_start;
   logic [63:0]   cur_end;
   logic [64:0]   lead_sum;
   logic          issue_ok;
   logic          missed_now;
   logic [CW-1:0] idx_inc;
   logic          wrap;
   logic [IW-1:0] next_index;

   // Table storage; outputs are latched from the old contents when a write collides with an issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_port[i]  <= 16'd0;
            tbl_buf[i]   <= 16'd0;
            tbl_start[i] <= 64'd0;
            tbl_end[i]   <= 64'd0;
            tbl_flow[i]  <= 16'd0;
            tbl_len[i]   <= 16'd0;
         end
      end else if (cfg_wr) begin
         tbl_port[cfg_addr]  <= cfg_port_number;
         tbl_buf[cfg_addr]   <= cfg_buffer_number;
         tbl_start[cfg_addr] <= cfg_window_start;
         tbl_end[cfg_addr]   <= cfg_window_end;
         tbl_flow[cfg_addr]  <= cfg_flow_id;
         tbl_len[cfg_addr]   <= cfg_tt_length;
      end
   end

   // Window compare is done 65 bits wide so time + LEAD never wraps past zero.
   always_comb begin
      cur_start  = tbl_start[out_entry_index];
      cur_end    = tbl_end[out_entry_index];
      lead_sum   = {1'b0, in_global_time} + 65'(LEAD);
      issue_ok   = (lead_sum >= {1'b0, cur_start});
      missed_now = (in_global_time > cur_end);
      idx_inc    = CW'(out_entry_index) + CW'(1);
      wrap       = (idx_inc >= cfg_entry_count);
      if (wrap) begin
         next_index = '0;
      end else begin
         next_index = idx_inc[IW-1:0];
      end
   end

   // Schedule sequencer with registered strobe, miss pulse, index and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         hold_seen         <= 1'b0;
         out_table_wr      <= 1'b0;
         out_missed        <= 1'b0;
         out_entry_index   <= '0;
         out_cycle_count   <= 16'd0;
         out_miss_count    <= 16'd0;
         out_port_number   <= 16'd0;
         out_buffer_number <= 16'd0;
         out_window_start  <= 64'd0;
         out_window_end    <= 64'd0;
         out_flow_id       <= 16'd0;
         out_tt_length     <= 16'd0;
      end else begin
         out_table_wr <= 1'b0;
         out_missed   <= 1'b0;
         case (state)
            IDLE: begin
               out_entry_index <= '0;
               if (cfg_enable && (cfg_entry_count != '0)) begin
                  state <= EVAL;
               end else begin
                  state <= IDLE;
               end
            end
            EVAL: begin
               if (!cfg_enable || (cfg_entry_count == '0)) begin
                  state           <= IDLE;
                  out_entry_index <= '0;
               end else if (missed_now) begin
                  out_missed      <= 1'b1;
                  out_miss_count  <= out_miss_count + 16'd1;
                  out_entry_index <= next_index;
                  if (wrap) begin
                     out_cycle_count <= out_cycle_count + 16'd1;
                  end
               end else if (issue_ok && in_table_rdy) begin
                  state             <= ISSUE;
                  out_table_wr      <= 1'b1;
                  out_port_number   <= tbl_port[out_entry_index];
                  out_buffer_number <= tbl_buf[out_entry_index];
                  out_window_start  <= cur_start;
                  out_window_end    <= cur_end;
                  out_flow_id       <= tbl_flow[out_entry_index];
                  out_tt_length     <= tbl_len[out_entry_index];
               end else begin
                  state <= EVAL;
               end
            end
            ISSUE: begin
               out_entry_index <= next_index;
               if (wrap) begin
                  out_cycle_count <= out_cycle_count + 16'd1;
               end
               hold_seen <= 1'b0;
               state     <= HOLD;
            end
            HOLD: begin
               // The first HOLD cycle ignores rdy so a stale high level is not counted twice.
               if (!hold_seen) begin
                  hold_seen <= 1'b1;
               end else if (!cfg_enable) begin
                  state           <= IDLE;
                  out_entry_index <= '0;
               end else if (in_table_rdy) begin
                  state <= EVAL;
               end else begin
                  state <= HOLD;
               end
            end
            default: begin
               state           <= IDLE;
               out_entry_index <= '0;
            end
         endcase
      end
   end

   // TT frame tracker: flag rises on a frame's first word, and that set beats a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_frame    <= 1'b0;
         out_tt_flag <= 1'b0;
      end else begin
         if (in_tt_wr) begin
            in_frame <= (in_tt_ctrl != 8'd1);
         end
         if (in_tt_wr && !in_frame) begin
            out_tt_flag <= 1'b1;
         end else if (in_tt_flag_clear) begin
            out_tt_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tt_schedule_table.sv
// Scoreboard bench for tt_schedule_table: expected entries are queued when scheduled
// and compared against each out_table_wr strobe by a negedge monitor.
module tb_tt_schedule_table;

   typedef struct {
      logic [15:0] port;
      logic [15:0] bufn;
      logic [63:0] ws;
      logic [63:0] we;
      logic [15:0] flow;
      logic [15:0] len;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_wr = 1'b0;
   logic [2:0]  cfg_addr = 3'd0;
   logic [15:0] cfg_port_number = 16'd0;
   logic [15:0] cfg_buffer_number = 16'd0;
   logic [63:0] cfg_window_start = 64'd0;
   logic [63:0] cfg_window_end = 64'd0;
   logic [15:0] cfg_flow_id = 16'd0;
   logic [15:0] cfg_tt_length = 16'd0;
   logic [3:0]  cfg_entry_count = 4'd0;
   logic        cfg_enable = 1'b0;
   logic        in_table_rdy = 1'b0;
   logic [63:0] in_global_time = 64'd0;
   logic        in_tt_wr = 1'b0;
   logic [7:0]  in_tt_ctrl = 8'd0;
   logic        in_tt_flag_clear = 1'b0;
   logic        out_table_wr;
   logic [15:0] out_port_number;
   logic [15:0] out_buffer_number;
   logic [63:0] out_window_start;
   logic [63:0] out_window_end;
   logic [15:0] out_flow_id;
   logic [15:0] out_tt_length;
   logic        out_tt_flag;
   logic        out_missed;
   logic [2:0]  out_entry_index;
   logic [15:0] out_cycle_count;
   logic [15:0] out_miss_count;

   int     n_checks = 0;
   int     n_pass = 0;
   int     strobe_cnt = 0;
   int     miss_pulses = 0;
   logic   prev_wr = 1'b0;
   entry_t sb[$];

   tt_schedule_table dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_port_number(cfg_port_number), .cfg_buffer_number(cfg_buffer_number),
      .cfg_window_start(cfg_window_start), .cfg_window_end(cfg_window_end),
      .cfg_flow_id(cfg_flow_id), .cfg_tt_length(cfg_tt_length),
      .cfg_entry_count(cfg_entry_count), .cfg_enable(cfg_enable),
      .in_table_rdy(in_table_rdy), .in_global_time(in_global_time),
      .in_tt_wr(in_tt_wr), .in_tt_ctrl(in_tt_ctrl), .in_tt_flag_clear(in_tt_flag_clear),
      .out_table_wr(out_table_wr), .out_port_number(out_port_number),
      .out_buffer_number(out_buffer_number), .out_window_start(out_window_start),
      .out_window_end(out_window_end), .out_flow_id(out_flow_id),
      .out_tt_length(out_tt_length), .out_tt_flag(out_tt_flag), .out_missed(out_missed),
      .out_entry_index(out_entry_index), .out_cycle_count(out_cycle_count),
      .out_miss_count(out_miss_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input logic [2:0] addr, input entry_t e);
      cfg_wr = 1'b1; cfg_addr = addr;
      cfg_port_number = e.port; cfg_buffer_number = e.bufn;
      cfg_window_start = e.ws; cfg_window_end = e.we;
      cfg_flow_id = e.flow; cfg_tt_length = e.len;
      step();
      cfg_wr = 1'b0;
   endtask

   task automatic wait_strobe(input string tag);
      int n = 0;
      while (!out_table_wr && n < 40) begin
         step();
         n++;
      end
      if (!out_table_wr) check_val(tag, 64'd0, 64'd1);
   endtask

   // Scoreboard monitor: every strobe pops one expected entry and must not follow another strobe.
   always @(negedge clk) begin
      if (rst) begin
         prev_wr = 1'b0;
      end else begin
         if (out_missed) miss_pulses++;
         if (out_table_wr) begin
            strobe_cnt++;
            check_val("no_back_to_back", {63'd0, prev_wr}, 64'd0);
            if (sb.size() == 0) begin
               check_val("unexpected_strobe", 64'd1, 64'd0);
            end else begin
               entry_t e;
               e = sb.pop_front();
               check_val("sb_port", {48'd0, out_port_number}, {48'd0, e.port});
               check_val("sb_buf", {48'd0, out_buffer_number}, {48'd0, e.bufn});
               check_val("sb_start", out_window_start, e.ws);
               check_val("sb_end", out_window_end, e.we);
               check_val("sb_flow", {48'd0, out_flow_id}, {48'd0, e.flow});
               check_val("sb_len", {48'd0, out_tt_length}, {48'd0, e.len});
            end
         end
         prev_wr = out_table_wr;
      end
   end

   initial begin
      entry_t e0, e1, e2, en;
      int base;

      // Reset state
      step(); step();
      check_val("rst_wr", {63'd0, out_table_wr}, 64'd0);
      check_val("rst_start", out_window_start, 64'd0);
      check_val("rst_cycle", {48'd0, out_cycle_count}, 64'd0);
      check_val("rst_miss", {48'd0, out_miss_count}, 64'd0);
      check_val("rst_index", {61'd0, out_entry_index}, 64'd0);
      check_val("rst_flag", {63'd0, out_tt_flag}, 64'd0);
      rst = 1'b0;
      step();

      // Lead-time boundary: 83+16 < 100 stays silent, 84+16 == 100 issues
      e0 = '{16'd2, 16'd1, 64'd100, 64'd200, 16'd7, 16'd64};
      write_entry(3'd0, e0);
      cfg_entry_count = 4'd1; in_table_rdy = 1'b1; in_global_time = 64'd83; cfg_enable = 1'b1;
      repeat (10) step();
      check_val("t83_no_strobe", strobe_cnt, 64'd0);
      sb.push_back(e0);
      in_global_time = 64'd84;
      wait_strobe("t84_strobe_timeout");
      cfg_enable = 1'b0;
      repeat (4) step();
      check_val("t84_strobes", strobe_cnt, 64'd1);
      check_val("t84_cycle", {48'd0, out_cycle_count}, 64'd1);
      check_val("t84_start_held", out_window_start, 64'd100);
      check_val("t84_index", {61'd0, out_entry_index}, 64'd0);

      // Missed window on entry 1, entry 2 issued next, index wraps
      e0 = '{16'd10, 16'd1, 64'd400, 64'd5000, 16'd1, 16'd1};
      e1 = '{16'd11, 16'd2, 64'd100, 64'd200, 16'd2, 16'd2};
      e2 = '{16'd12, 16'd3, 64'd300, 64'd5000, 16'd3, 16'd3};
      write_entry(3'd0, e0); write_entry(3'd1, e1); write_entry(3'd2, e2);
      cfg_entry_count = 4'd3; in_global_time = 64'd500;
      base = strobe_cnt;
      sb.push_back(e0); sb.push_back(e2);
      cfg_enable = 1'b1;
      wait_strobe("miss_first_timeout");
      step();
      wait_strobe("miss_second_timeout");
      cfg_enable = 1'b0;
      repeat (5) step();
      check_val("miss_strobes", strobe_cnt - base, 64'd2);
      check_val("miss_pulses", miss_pulses, 64'd1);
      check_val("miss_count", {48'd0, out_miss_count}, 64'd1);
      check_val("miss_cycle", {48'd0, out_cycle_count}, 64'd2);
      check_val("miss_last_port", {48'd0, out_port_number}, 64'd12);
      check_val("miss_index_wrap", {61'd0, out_entry_index}, 64'd0);

      // Checker handshake: one strobe per rdy low/high cycle
      e0 = '{16'd20, 16'd5, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 16'd4, 16'd4};
      write_entry(3'd0, e0);
      cfg_entry_count = 4'd1; in_global_time = 64'd84; in_table_rdy = 1'b1;
      base = strobe_cnt;
      cfg_enable = 1'b1;
      for (int r = 0; r < 3; r++) begin
         sb.push_back(e0);
         wait_strobe("rdy_round_timeout");
         in_table_rdy = 1'b0;
         if (r == 2) cfg_enable = 1'b0;
         repeat (3) step();
         in_table_rdy = 1'b1;
      end
      repeat (6) step();
      check_val("rdy_strobes", strobe_cnt - base, 64'd3);

      // Frame tracker
      in_tt_wr = 1'b1; in_tt_ctrl = 8'd0; step();
      check_val("frame_first", {63'd0, out_tt_flag}, 64'd1);
      step();
      in_tt_ctrl = 8'd1; step();
      in_tt_wr = 1'b0; in_tt_ctrl = 8'd0;
      check_val("frame_end_flag", {63'd0, out_tt_flag}, 64'd1);
      step();
      check_val("frame_held", {63'd0, out_tt_flag}, 64'd1);
      in_tt_flag_clear = 1'b1; step(); in_tt_flag_clear = 1'b0;
      check_val("frame_cleared", {63'd0, out_tt_flag}, 64'd0);
      in_tt_flag_clear = 1'b1; in_tt_wr = 1'b1; step();
      check_val("frame_set_wins", {63'd0, out_tt_flag}, 64'd1);
      in_tt_ctrl = 8'd1; step();
      in_tt_wr = 1'b0; in_tt_ctrl = 8'd0; in_tt_flag_clear = 1'b0;
      check_val("frame_clear_mid", {63'd0, out_tt_flag}, 64'd0);
      in_tt_wr = 1'b1; in_tt_ctrl = 8'd1; step();
      in_tt_wr = 1'b0; in_tt_ctrl = 8'd0;
      check_val("single_word_set", {63'd0, out_tt_flag}, 64'd1);
      in_tt_flag_clear = 1'b1; step(); in_tt_flag_clear = 1'b0;
      in_tt_wr = 1'b1; step(); in_tt_wr = 1'b0;
      check_val("single_word_ended", {63'd0, out_tt_flag}, 64'd1);
      in_tt_flag_clear = 1'b1; in_tt_ctrl = 8'd1; in_tt_wr = 1'b1; step();
      in_tt_wr = 1'b0; in_tt_ctrl = 8'd0; in_tt_flag_clear = 1'b0;

      // Write collision in the ISSUE cycle, then reset mid-ISSUE
      e0 = '{16'd5, 16'd3, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 16'd10};
      en = '{16'd9, 16'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 16'd20};
      write_entry(3'd0, e0);
      sb.push_back(e0);
      cfg_enable = 1'b1;
      wait_strobe("coll_timeout");
      sb.push_back(en);
      write_entry(3'd0, en);
      check_val("coll_old_port", {48'd0, out_port_number}, 64'd5);
      check_val("coll_old_len", {48'd0, out_tt_length}, 64'd10);
      wait_strobe("coll_new_timeout");
      check_val("coll_new_port", {48'd0, out_port_number}, 64'd9);
      rst = 1'b1; #1;
      check_val("rst_issue_wr", {63'd0, out_table_wr}, 64'd0);
      check_val("rst_issue_port", {48'd0, out_port_number}, 64'd0);
      sb.delete();
      cfg_enable = 1'b0;
      step(); rst = 1'b0; step();

      // Table cleared by reset: entry 0 now has window_end 0, so it is missed
      cfg_entry_count = 4'd1; in_global_time = 64'd84; base = strobe_cnt;
      cfg_enable = 1'b1;
      repeat (4) step();
      cfg_enable = 1'b0;
      repeat (2) step();
      check_val("tbl_cleared_miss", {63'd0, out_miss_count != 16'd0}, 64'd1);
      check_val("tbl_cleared_nostrobe", strobe_cnt - base, 64'd0);

      // Reset during HOLD, then restart from entry 0
      e0 = '{16'd2, 16'd1, 64'd100, 64'd200, 16'd7, 16'd64};
      write_entry(3'd0, e0);
      sb.push_back(e0);
      cfg_enable = 1'b1;
      wait_strobe("hold_timeout");
      in_tt_wr = 1'b1; in_tt_ctrl = 8'd1; step();
      in_tt_wr = 1'b0; in_tt_ctrl = 8'd0;
      check_val("hold_flag_set", {63'd0, out_tt_flag}, 64'd1);
      rst = 1'b1; #1;
      check_val("hold_rst_start", out_window_start, 64'd0);
      check_val("hold_rst_cycle", {48'd0, out_cycle_count}, 64'd0);
      check_val("hold_rst_miss", {48'd0, out_miss_count}, 64'd0);
      check_val("hold_rst_flag", {63'd0, out_tt_flag}, 64'd0);
      check_val("hold_rst_index", {61'd0, out_entry_index}, 64'd0);
      cfg_enable = 1'b0;
      step(); rst = 1'b0; step();
      write_entry(3'd0, e0);
      sb.push_back(e0);
      base = strobe_cnt;
      cfg_enable = 1'b1;
      wait_strobe("restart_timeout");
      check_val("restart_index", {61'd0, out_entry_index}, 64'd0);
      cfg_enable = 1'b0;
      repeat (5) step();
      check_val("restart_strobes", strobe_cnt - base, 64'd1);
      check_val("restart_cycle", {48'd0, out_cycle_count}, 64'd1);

      check_val("sb_empty", sb.size(), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
